// File: rtl/hps_reset_req_gen.sv
// Debounced push-button to HPS cold/warm/debug reset-request pulse generator.
// Define HPS_RESET_REQ_DEBUG_EN to build the debug channel (key_n[2]).
module hps_reset_req_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [2:0] key_n,
  input  logic       hps_0_h2f_reset_reset_n,
  output logic       hps_0_f2h_cold_reset_req_reset_n,
  output logic       hps_0_f2h_warm_reset_req_reset_n,
  output logic       hps_0_f2h_debug_reset_req_reset_n,
  output logic       busy
);

`ifdef HPS_RESET_REQ_DEBUG_EN
  localparam int unsigned NK = 3;
`else
  localparam int unsigned NK = 2;
  logic unused_debug_key;
  assign unused_debug_key = key_n[2];
`endif

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  logic [NK-1:0]  key_s1, key_s2, key_deb, key_armed, press;
  logic [DCW-1:0] deb_cnt [NK];
  logic           h2f_s1, h2f_s2;
  logic [1:0]     fill;

  state_t         state, state_d;
  logic [1:0]     chan, chan_d;
  logic [PCW-1:0] pcnt, pcnt_d;
  logic [NK-1:0]  req_n_d, req_n_q;
  logic           busy_d, busy_q;
  logic [2:0]     press3;
  logic           keys_released;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
      h2f_s1 <= 1'b1;
      h2f_s2 <= 1'b1;
      fill   <= '0;
    end else begin
      key_s1 <= key_n[NK-1:0];
      key_s2 <= key_s1;
      h2f_s1 <= hps_0_h2f_reset_reset_n;
      h2f_s2 <= h2f_s1;
      fill   <= {fill[0], 1'b1};
    end
  end

  // A key is armed only once its synchronized level has been seen released
  // after reset, so a button held through reset cannot issue a request.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_deb   <= '1;
      key_armed <= '0;
      press     <= '0;
      for (int unsigned i = 0; i < NK; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NK; i++) begin
        press[i] <= 1'b0;
        if (key_s2[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          key_deb[i] <= key_s2[i];
          press[i]   <= key_armed[i] & ~key_s2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
        if (fill[1] && key_s2[i]) key_armed[i] <= 1'b1;
      end
    end
  end

  assign press3        = 3'(press);
  assign keys_released = &key_deb;

  always_comb begin
    state_d = state;
    chan_d  = chan;
    pcnt_d  = pcnt;
    case (state)
      IDLE: begin
        if (|press3) begin
          state_d = ASSERT;
          pcnt_d  = '0;
          if (press3[0])      chan_d = 2'd0;
          else if (press3[1]) chan_d = 2'd1;
          else                chan_d = 2'd2;
        end
      end
      ASSERT: begin
        if (pcnt == PULSE_LAST) state_d = HOLDOFF;
        else                    pcnt_d  = pcnt + PCW'(1);
      end
      HOLDOFF: begin
        if (keys_released && h2f_s2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so every pin comes from a flop.
    req_n_d = '1;
    for (int unsigned i = 0; i < NK; i++)
      req_n_d[i] = !((state_d == ASSERT) && (chan_d == 2'(i)));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      chan    <= '0;
      pcnt    <= '0;
      req_n_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      chan    <= chan_d;
      pcnt    <= pcnt_d;
      req_n_q <= req_n_d;
      busy_q  <= busy_d;
    end
  end

  assign hps_0_f2h_cold_reset_req_reset_n = req_n_q[0];
  assign hps_0_f2h_warm_reset_req_reset_n = req_n_q[1];
`ifdef HPS_RESET_REQ_DEBUG_EN
  assign hps_0_f2h_debug_reset_req_reset_n = req_n_q[2];
`else
  assign hps_0_f2h_debug_reset_req_reset_n = 1'b1;
`endif
  assign busy = busy_q;

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// Self-checking bench for hps_reset_req_gen: directed scenarios plus random
// key/HPS-reset activity checked every cycle against a queue-based model.
module tb_hps_reset_req_gen;

  localparam int DEB = 4;
  localparam int PUL = 3;
`ifdef HPS_RESET_REQ_DEBUG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [2:0] key_n;
  logic       h2f_n;
  logic       cold_n, warm_n, dbg_n, busy;

  always #5 clk_clk = ~clk_clk;

  hps_reset_req_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL)
  ) dut (
    .clk_clk                          (clk_clk),
    .reset_reset_n                    (reset_reset_n),
    .key_n                            (key_n),
    .hps_0_h2f_reset_reset_n          (h2f_n),
    .hps_0_f2h_cold_reset_req_reset_n (cold_n),
    .hps_0_f2h_warm_reset_req_reset_n (warm_n),
    .hps_0_f2h_debug_reset_req_reset_n(dbg_n),
    .busy                             (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: sync delay as a 2-deep sample queue, debounce as a
  // sliding window of the last DEB synchronized samples.
  bit kq [3][$];
  bit hq [$];
  bit win [3][$];
  bit m_deb [3];
  bit m_armed [3];
  bit m_strobe [3];
  int m_edges, m_mode, m_chan, m_left;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      kq[k] = '{1'b1, 1'b1};
      win[k].delete();
      m_deb[k] = 1'b1;
      m_armed[k] = 1'b0;
      m_strobe[k] = 1'b0;
    end
    hq = '{1'b1, 1'b1};
    m_edges = 0;
    m_mode = 0;
    m_chan = 0;
    m_left = 0;
  endtask

  task automatic model_edge();
    bit sp [3];
    bit hp, released, all_diff, ns;
    m_edges++;
    for (int k = 0; k < 3; k++) begin
      sp[k] = kq[k].pop_front();
      kq[k].push_back(key_n[k]);
    end
    hp = hq.pop_front();
    hq.push_back(h2f_n);
    released = 1'b1;
    for (int k = 0; k < 3; k++)
      if (k < 2 || DBG_EN) released = released & m_deb[k];
    case (m_mode)
      0: begin
        for (int k = 2; k >= 0; k--)
          if (m_strobe[k]) begin m_chan = k; m_mode = 1; m_left = PUL; end
      end
      1: begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
      default: if (released && hp) m_mode = 0;
    endcase
    for (int k = 0; k < 3; k++) begin
      ns = 1'b0;
      if (k < 2 || DBG_EN) begin
        win[k].push_back(sp[k]);
        if (win[k].size() > DEB) void'(win[k].pop_front());
        all_diff = (win[k].size() == DEB);
        foreach (win[k][j]) if (win[k][j] == m_deb[k]) all_diff = 1'b0;
        if (all_diff) begin
          ns = m_deb[k] & m_armed[k];
          m_deb[k] = !m_deb[k];
        end
        if (m_edges >= 3 && sp[k]) m_armed[k] = 1'b1;
      end
      m_strobe[k] = ns;
    end
  endtask

  int cyc = 0;
  int lows [3];
  int first_low [3];
  int busy_lo, busy_hi;

  task automatic clear_obs();
    for (int k = 0; k < 3; k++) begin lows[k] = 0; first_low[k] = -1; end
    busy_lo = 0;
    busy_hi = 0;
  endtask

  task automatic step();
    logic [2:0] obs;
    @(posedge clk_clk);
    if (reset_reset_n) model_edge();
    @(negedge clk_clk);
    cyc++;
    check_eq("cold_n", cold_n, !(m_mode == 1 && m_chan == 0));
    check_eq("warm_n", warm_n, !(m_mode == 1 && m_chan == 1));
    check_eq("debug_n", dbg_n, !(m_mode == 1 && m_chan == 2));
    check_eq("busy", busy, m_mode != 0);
    obs = {dbg_n, warm_n, cold_n};
    for (int k = 0; k < 3; k++)
      if (!obs[k]) begin
        lows[k]++;
        if (first_low[k] < 0) first_low[k] = cyc;
      end
    if (busy) busy_hi++; else busy_lo++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int fall;

  initial begin
    reset_reset_n = 1'b0;
    key_n = 3'b111;
    h2f_n = 1'b1;
    model_reset();
    run(3);
    reset_reset_n = 1'b1;
    run(5);

    // clean press
    clear_obs();
    key_n[0] = 1'b0;
    run(20);
    check_eq("clean_cold_len", lows[0], PUL);
    check_eq("clean_warm_len", lows[1], 0);
    key_n[0] = 1'b1;
    run(20);

    // bounce then settle low
    for (int i = 0; i < 6; i++) begin
      key_n[1] = (i % 2 == 1);
      run(2);
    end
    key_n[1] = 1'b0;
    fall = cyc;
    clear_obs();
    run(20);
    check_eq("bounce_warm_len", lows[1], PUL);
    check_eq("bounce_start", first_low[1] - fall, 2 + DEB + 1);
    key_n[1] = 1'b1;
    run(20);

    // simultaneous cold + warm
    clear_obs();
    key_n[1:0] = 2'b00;
    run(15);
    check_eq("simul_cold_len", lows[0], PUL);
    check_eq("simul_warm_len", lows[1], 0);
    key_n[1:0] = 2'b11;
    run(20);

    // HPS reset holdoff with a debug press inside the window
    clear_obs();
    key_n[1] = 1'b0;
    for (int t = 0; t < 40 && !(lows[1] == PUL && warm_n); t++) step();
    check_eq("holdoff_pulse", lows[1], PUL);
    h2f_n = 1'b0;
    key_n[1] = 1'b1;
    clear_obs();
    run(5);
    key_n[2] = 1'b0;
    run(10);
    key_n[2] = 1'b1;
    run(35);
    check_eq("holdoff_busy_lo", busy_lo, 0);
    check_eq("holdoff_dbg_len", lows[2], 0);
    h2f_n = 1'b1;
    run(20);

    // reset during the second pulse cycle with key still held
    clear_obs();
    key_n[0] = 1'b0;
    for (int t = 0; t < 40 && cold_n; t++) step();
    check_eq("rst_first_low", cold_n, 0);
    step();
    check_eq("rst_second_low", cold_n, 0);
    #1 reset_reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_cold", cold_n, 1);
    check_eq("rst_async_busy", busy, 0);
    run(3);
    reset_reset_n = 1'b1;
    clear_obs();
    run(30);
    check_eq("rst_held_no_req", lows[0], 0);
    check_eq("rst_held_no_busy", busy_hi, 0);
    key_n[0] = 1'b1;
    run(20);

    // debug channel
    clear_obs();
    key_n[2] = 1'b0;
    run(20);
`ifdef HPS_RESET_REQ_DEBUG_EN
    check_eq("dbg_len", lows[2], PUL);
`else
    check_eq("dbg_len", lows[2], 0);
    check_eq("dbg_busy", busy_hi, 0);
`endif
    key_n[2] = 1'b1;
    run(20);

    // random activity with occasional resets
    for (int it = 0; it < 400; it++) begin
      key_n = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      h2f_n = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) begin
        reset_reset_n = 1'b0;
        model_reset();
        run(2);
        reset_reset_n = 1'b1;
      end
      run($urandom_range(1, 10));
    end
    key_n = 3'b111;
    h2f_n = 1'b1;
    run(30);
    check_eq("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_reset_req_gen.md
HPS_RESET_REQ_GEN -- requirements
Module: hps_reset_req_gen

Interface
REQ-001 Param DEBOUNCE_CYCLES, default 1000000, is the number of stable cycles needed before a key change is accepted (20 ms at 50 MHz); legal range is 2 or more.
REQ-002 Param PULSE_CYCLES, default 16, is the number of cycles a reset-request output is held low; legal range is 1 or more.
REQ-003 Clock and reset SHALL be named exactly as in the HPS system, as follows:
- clk_clk  in  1  single system clock; all logic on rising edge.
- reset_reset_n  in  1  reset; asynchronous, active-low.
REQ-004 The remaining ports SHALL be:
- key_n  in  3  raw push buttons, asynchronous, active-low; [0]=cold, [1]=warm, [2]=debug.
- hps_0_h2f_reset_reset_n  in  1  HPS-to-fabric reset, asynchronous, active-low.
- hps_0_f2h_cold_reset_req_reset_n  out  1  cold request to HPS, active-low.
- hps_0_f2h_warm_reset_req_reset_n  out  1  warm request to HPS, active-low.
- hps_0_f2h_debug_reset_req_reset_n  out  1  debug request to HPS, active-low.
- busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-005 Each key_n bit and hps_0_h2f_reset_reset_n SHALL pass through a 2-flop synchronizer before any use.
REQ-006 Each key SHALL have its own debounce counter, sized with $clog2(DEBOUNCE_CYCLES):
- counter clears whenever the synchronized value equals the debounced value, or on any mismatch-free cycle;
- counter increments while the two differ;
- on reaching DEBOUNCE_CYCLES-1, the debounced value takes the synchronized value and the counter clears.
REQ-007 A press event SHALL be a debounced 1->0 transition; it is a single-cycle strobe per key.
REQ-008 The FSM SHALL have three states: IDLE, ASSERT, HOLDOFF.
REQ-009 In IDLE, any press strobe SHALL latch the selected channel and move to ASSERT on the next edge.
- Simultaneous strobes are resolved by priority: cold > warm > debug.
- Only one channel is ever latched.
REQ-010 In ASSERT, only the latched channel's output SHALL be driven low, registered, for exactly PULSE_CYCLES consecutive cycles starting on the cycle after the strobe.
- The FSM then moves to HOLDOFF.
REQ-011 In HOLDOFF, the FSM SHALL return to IDLE only when all debounced keys read 1 and the synchronized hps_0_h2f_reset_reset_n reads 1.
REQ-012 Press strobes in ASSERT or HOLDOFF SHALL be discarded, not queued.
REQ-013 No more than one output SHALL ever be low at a time, and outputs SHALL be glitch-free (driven directly from flops).
REQ-014 A key held down continuously SHALL produce exactly one request; a new request requires release, then re-press.

Reset
REQ-015 While reset_reset_n=0, the block SHALL hold:
- all request outputs at 1;
- busy at 0;
- FSM in IDLE;
- synchronizers and debounced values at 1;
- counters at 0.
REQ-016 Reset asserted mid-ASSERT SHALL release the active request output to 1 asynchronously.
REQ-017 After reset release, no request SHALL be issued unless a key undergoes a full debounced press; a key held through reset must be released, then re-pressed.

Configuration
REQ-018 Macro HPS_RESET_REQ_DEBUG_EN SHALL control the debug channel:
- Defined: the debug channel operates per REQ-006 to REQ-014.
- Undefined: key_n[2] is ignored, no debounce logic is built for it, and hps_0_f2h_debug_reset_req_reset_n is tied to 1. Port list is unchanged.

Verification
REQ-019 The bench SHALL use DEBOUNCE_CYCLES=4 and PULSE_CYCLES=3, and SHALL cover these scenarios:
- Clean press: key_n[0] goes low and is held 20 cycles -> cold_req_n low for exactly 3 cycles; busy high from the first low cycle until key release plus debounce.
- Bounce: key_n[1] toggles every 2 cycles for 12 cycles, then stays low -> exactly one warm pulse of 3 cycles, starting 4+2 cycles after the final fall, plus 1 cycle for the strobe.
- Simultaneous press: key_n[0] and key_n[1] fall in the same cycle -> cold pulse only; warm_req_n stays 1 throughout.
- HPS reset holdoff: press warm and hold hps_0_h2f_reset_reset_n low 50 cycles after the pulse -> busy stays 1 until that input returns to 1; a debug press during that window yields no pulse.
- Reset mid-pulse: reset_reset_n low during the 2nd pulse cycle -> output returns to 1 immediately; no request after release while key_n[0] is still held.
- Macro undefined: debug key pressed -> debug_req_n constant 1 and busy stays 0.
